// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: reset PC, word width and the fetch entry
// handed from fetch to decode.
package dlx_pkg;

  localparam int unsigned DLX_WORD_W   = 32;
  localparam logic [31:0] DLX_RESET_PC = 32'h00400020;
  localparam logic [31:0] DLX_NOP      = 32'h00000000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    IF_RST  = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } ifetch_state_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Shift-style synchronous FIFO: entry 0 is always the head, so the head
// outputs come straight from flops. Same-edge push and pop are legal when full.
module ifetch_buf #(
  parameter int unsigned       WIDTH     = 96,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             placed;

  // Valid bits stay thermometer-coded: pop shifts down, push fills lowest hole.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    placed  = 1'b0;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          valid_d[i] = valid_q[i+1];
          data_d[i]  = data_q[i+1];
        end
        valid_d[DEPTH-1] = 1'b0;
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (!valid_d[i] && !placed) begin
            valid_d[i] = 1'b1;
            data_d[i]  = wdata;
            placed     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
    end
  end

  assign head  = data_q[0];
  assign full  = valid_q[DEPTH-1];
  assign empty = !valid_q[0];

endmodule

// File: rtl/dlx_ifetch.sv
// DLX instruction-fetch initiator: owns the fetch PC, drives the sram read
// port and queues fetched words for decode over a valid/ready handshake.
module dlx_ifetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DLX_RESET_PC,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [0:31] mem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [0:31] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ENTRY_W = FETCH_ENTRY_W + DLX_WORD_W;
  localparam logic [ENTRY_W-1:0] ENTRY_RESET = {32'h0, DLX_NOP, 32'h0};

  ifetch_state_t         state_q, state_d;
  logic [DLX_WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_cs_q;
  logic [DLX_WORD_W-1:0] mem_addr_q;

  logic                  push, pop, flush, slot_free, lat_done;
  logic                  buf_full, buf_empty;
  fetch_entry_t          wr_entry, head_entry;
  logic [ENTRY_W-1:0]    wr_data, head;

  assign lat_done  = (cnt_q == CNT_W'(MEM_LATENCY));
  assign pop       = if_valid && if_ready;
  assign slot_free = !buf_full || pop;
  assign flush     = redirect_valid && (state_q != IF_RST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IF_RST;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_RST:  state_d = IF_REQ;
      IF_REQ:  if (!redirect_valid && lat_done && !slot_free) state_d = IF_HOLD;
      IF_HOLD: if (redirect_valid || slot_free) state_d = IF_REQ;
      default: state_d = IF_RST;
    endcase
  end

  // Fetch PC, wait counter and capture control; redirect outranks capture.
  always_comb begin
    push       = 1'b0;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    if (flush) begin
      fetch_pc_d = word_align(redirect_pc);
      cnt_d      = CNT_W'(1);
    end else begin
      unique case (state_q)
        IF_RST: begin
          fetch_pc_d = RESET_PC;
          cnt_d      = CNT_W'(1);
        end
        IF_REQ: begin
          if (!lat_done) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (slot_free) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            cnt_d      = CNT_W'(1);
          end
        end
        IF_HOLD: begin
          if (slot_free) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            cnt_d      = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      cnt_q      <= CNT_W'(1);
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      mem_cs_q   <= (state_d != IF_RST);
      mem_addr_q <= fetch_pc_d;
    end
  end

  assign mem_cs   = mem_cs_q;
  assign mem_oe   = mem_cs_q;
  assign mem_we   = 1'b0;
  assign mem_din  = '0;
  assign mem_addr = mem_addr_q;

  // npc travels with the entry so the head outputs are all flops.
  assign wr_entry = '{instr: mem_dout, pc: fetch_pc_q};
  assign wr_data  = {fetch_pc_q + 32'd4, wr_entry};

  ifetch_buf #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (BUF_DEPTH),
    .RESET_VAL (ENTRY_RESET)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_data),
    .head  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign head_entry = head[FETCH_ENTRY_W-1:0];
  assign if_valid   = !buf_empty;
  assign if_instr   = head_entry.instr;
  assign if_pc      = head_entry.pc;
  assign if_npc     = head[ENTRY_W-1 -: DLX_WORD_W];

endmodule

// File: tb/tb_dlx_ifetch.sv
// Bench for dlx_ifetch: two configurations (latency 1 / depth 2 and latency 3 /
// depth 4) checked every cycle against a queue-level fetch model.
module tb_dlx_ifetch;

  localparam int unsigned L0 = 1;
  localparam int unsigned D0 = 2;
  localparam int unsigned L1 = 3;
  localparam int unsigned D1 = 4;
  localparam logic [31:0] RST_PC = 32'h00400020;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic        mem_cs   [2];
  logic        mem_oe   [2];
  logic        mem_we   [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_din  [2];
  logic [0:31] mem_dout [2];
  logic        if_valid [2];
  logic [0:31] if_instr [2];
  logic [31:0] if_pc    [2];
  logic [31:0] if_npc   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per configuration
  bit          m_active [2];
  bit          m_zero   [2];
  logic [31:0] m_fa     [2];
  int          m_age    [2];
  int          m_qn     [2];
  logic [31:0] m_qpc    [2][4];
  logic [31:0] m_qins   [2][4];
  logic [31:0] last_addr[2];
  int          run      [2];

  always #5 clk = ~clk;

  dlx_ifetch #(.MEM_LATENCY(L0), .BUF_DEPTH(D0)) u_dut0 (
    .clk(clk), .reset(reset),
    .mem_cs(mem_cs[0]), .mem_oe(mem_oe[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid[0]), .if_ready(if_ready), .if_instr(if_instr[0]),
    .if_pc(if_pc[0]), .if_npc(if_npc[0])
  );

  dlx_ifetch #(.MEM_LATENCY(L1), .BUF_DEPTH(D1)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_cs(mem_cs[1]), .mem_oe(mem_oe[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid[1]), .if_ready(if_ready), .if_instr(if_instr[1]),
    .if_pc(if_pc[1]), .if_npc(if_npc[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(L0) : int'(L1);
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? int'(D0) : int'(D1);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00400020: return 32'h2001AAAA;
      32'h00400024: return 32'h00220826;
      32'h00400028: return 32'h28220A0A;
      32'h0040002C: return 32'h1440FFF0;
      default:      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Fetch behaviour at a rising edge, in terms of request age and a queue.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_active[k] = 1'b0;
        m_qn[k]     = 0;
        m_fa[k]     = RST_PC;
        m_age[k]    = 0;
        m_zero[k]   = 1'b1;
      end else if (!m_active[k]) begin
        m_active[k] = 1'b1;
        m_fa[k]     = RST_PC;
        m_age[k]    = 1;
      end else if (redirect_valid) begin
        m_qn[k]  = 0;
        m_fa[k]  = {redirect_pc[31:2], 2'b00};
        m_age[k] = 1;
      end else begin
        if (m_qn[k] > 0 && if_ready) begin
          for (int i = 0; i < 3; i++) begin
            m_qpc[k][i]  = m_qpc[k][i+1];
            m_qins[k][i] = m_qins[k][i+1];
          end
          m_qn[k]--;
        end
        if (m_age[k] >= lat_of(k) && m_qn[k] < dep_of(k)) begin
          m_qpc[k][m_qn[k]]  = m_fa[k];
          m_qins[k][m_qn[k]] = mem_word(m_fa[k]);
          m_qn[k]++;
          m_fa[k]   = m_fa[k] + 32'd4;
          m_age[k]  = 1;
          m_zero[k] = 1'b0;
        end else begin
          m_age[k]++;
        end
      end
    end
  endtask

  // Sram model: data is only correct once the address has been held long enough.
  task automatic mem_update();
    for (int k = 0; k < 2; k++) begin
      if (mem_cs[k] && run[k] > 0 && mem_addr[k] == last_addr[k]) run[k]++;
      else run[k] = mem_cs[k] ? 1 : 0;
      last_addr[k] = mem_addr[k];
      mem_dout[k]  = (run[k] >= lat_of(k)) ? mem_word(mem_addr[k]) : 32'hDEADBEEF;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mem_cs%0d", k),   {31'b0, mem_cs[k]}, {31'b0, m_active[k]});
      check($sformatf("mem_oe%0d", k),   {31'b0, mem_oe[k]}, {31'b0, m_active[k]});
      check($sformatf("mem_we%0d", k),   {31'b0, mem_we[k]}, 32'h0);
      check($sformatf("mem_din%0d", k),  mem_din[k], 32'h0);
      check($sformatf("mem_addr%0d", k), mem_addr[k], m_active[k] ? m_fa[k] : 32'h0);
      check($sformatf("if_valid%0d", k), {31'b0, if_valid[k]}, {31'b0, (m_qn[k] > 0)});
      if (m_qn[k] > 0) begin
        check($sformatf("if_instr%0d", k), if_instr[k], m_qins[k][0]);
        check($sformatf("if_pc%0d", k),    if_pc[k],    m_qpc[k][0]);
        check($sformatf("if_npc%0d", k),   if_npc[k],   m_qpc[k][0] + 32'd4);
      end else if (m_zero[k]) begin
        check($sformatf("if_instr_rst%0d", k), if_instr[k], 32'h0);
        check($sformatf("if_pc_rst%0d", k),    if_pc[k],    32'h0);
        check($sformatf("if_npc_rst%0d", k),   if_npc[k],   32'h0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    mem_update();
    check_outputs();
  endtask

  task automatic run_phase(input int n, input bit rst, input bit rdy, input bit rv,
                           input logic [31:0] rpc);
    repeat (n) begin
      reset          = rst;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      tick();
    end
  endtask

  initial begin
    int          rdy_pct;
    bit          rst, rdy, rv;
    logic [31:0] rpc;
    reset          = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int k = 0; k < 2; k++) begin
      m_active[k]  = 1'b0;
      m_zero[k]    = 1'b1;
      m_fa[k]      = RST_PC;
      m_age[k]     = 0;
      m_qn[k]      = 0;
      last_addr[k] = '0;
      run[k]       = 0;
      mem_dout[k]  = '0;
    end

    // Directed walk through the fetch scenarios, then randomized traffic.
    run_phase(3,  1'b1, 1'b1, 1'b0, 32'h0);
    run_phase(8,  1'b0, 1'b1, 1'b0, 32'h0);
    run_phase(5,  1'b0, 1'b0, 1'b0, 32'h0);
    run_phase(6,  1'b0, 1'b1, 1'b0, 32'h0);
    run_phase(5,  1'b0, 1'b0, 1'b0, 32'h0);
    run_phase(1,  1'b0, 1'b1, 1'b1, 32'h00400022);
    run_phase(6,  1'b0, 1'b1, 1'b0, 32'h0);
    run_phase(14, 1'b0, 1'b0, 1'b0, 32'h0);
    run_phase(1,  1'b1, 1'b0, 1'b0, 32'h0);
    run_phase(8,  1'b0, 1'b1, 1'b0, 32'h0);
    run_phase(1,  1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    run_phase(12, 1'b0, 1'b1, 1'b0, 32'h0);

    rdy_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 20;
          1:       rdy_pct = 70;
          default: rdy_pct = 100;
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        1:       rpc = RST_PC + 32'($urandom_range(0, 63));
        default: rpc = $urandom();
      endcase
      run_phase(1, rst, rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
